// File: rtl/baud_gen_multi.sv
// baud_gen_multi
// Multi-channel fractional baud-rate generator. Each channel runs a
// fractional accumulator that emits an oversample clock-enable (ce_os) and,
// every OVERSAMPLE of those, a bit clock-enable (ce_bit). Rate values are
// written into a pending register and copied to the active register only at
// a safe point: while disabled, on restart, or on a tick. This means a
// running channel never sees a half-updated rate.
//
// Ports:
//   clock        global clock
//   reset_n      synchronous active-low reset, highest priority
//   cfg_we       write strobe for the pending rate registers
//   cfg_ch       channel addressed by cfg_we (out-of-range writes are dropped)
//   cfg_freq     accumulator increment for the addressed channel
//   cfg_limit    accumulator limit for the addressed channel
//   ch_enable    per-channel run enable (level)
//   ch_restart   per-channel phase restart (single-cycle pulse)
//   ce_os        per-channel oversample clock-enable pulses
//   ce_bit       per-channel bit clock-enable pulses (subset of ce_os)
//   cfg_pending  per-channel flag: written rate not yet committed
module baud_gen_multi #(
   parameter int NUM_CH     = 4,
   parameter int FREQ_W     = 12,
   parameter int LIMIT_W    = 16,
   parameter int OVERSAMPLE = 32,
   parameter int CH_W       = 2
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [FREQ_W-1:0]  cfg_freq,
   input  logic [LIMIT_W-1:0] cfg_limit,
   input  logic [NUM_CH-1:0]  ch_enable,
   input  logic [NUM_CH-1:0]  ch_restart,
   output logic [NUM_CH-1:0]  ce_os,
   output logic [NUM_CH-1:0]  ce_bit,
   output logic [NUM_CH-1:0]  cfg_pending
);

   localparam int ACC_W = LIMIT_W + 1;
   localparam int SUB_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);

   logic [NUM_CH-1:0][FREQ_W-1:0]  pendFreq_q,  pendFreq_d;
   logic [NUM_CH-1:0][LIMIT_W-1:0] pendLimit_q, pendLimit_d;
   logic [NUM_CH-1:0][FREQ_W-1:0]  actFreq_q,   actFreq_d;
   logic [NUM_CH-1:0][LIMIT_W-1:0] actLimit_q,  actLimit_d;
   logic [NUM_CH-1:0][ACC_W-1:0]   acc_q,       acc_d;
   logic [NUM_CH-1:0][SUB_W-1:0]   sub_q,       sub_d;
   logic [NUM_CH-1:0]              pend_q,      pend_d;
   logic [NUM_CH-1:0]              ceOs_q,      ceOs_d;
   logic [NUM_CH-1:0]              ceBit_q,     ceBit_d;

   logic [NUM_CH-1:0] chWrite;
   logic [NUM_CH-1:0] chTick;
   logic [NUM_CH-1:0] chCommit;

   // Per-channel decode. The channel index is compared as an int so that
   // a cfg_ch value at or above NUM_CH simply matches no channel.
   // A commit is safe whenever the accumulator phase is being discarded
   // (disable/restart) or has just wrapped (tick).
   always_comb begin
      chWrite  = '0;
      chTick   = '0;
      chCommit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         chWrite[i]  = cfg_we && (int'(cfg_ch) == i);
         chTick[i]   = acc_q[i] >= ACC_W'(actLimit_q[i]);
         chCommit[i] = !ch_enable[i] || ch_restart[i] || chTick[i];
      end
   end

   // Next-state for every channel. A write that lands on a commit edge
   // wins the pending flag: the commit moves the old pending value to
   // active while the new value is latched and still awaits its own commit.
   always_comb begin
      pendFreq_d  = pendFreq_q;
      pendLimit_d = pendLimit_q;
      actFreq_d   = actFreq_q;
      actLimit_d  = actLimit_q;
      acc_d       = acc_q;
      sub_d       = sub_q;
      pend_d      = pend_q;
      ceOs_d      = '0;
      ceBit_d     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (chWrite[i]) begin
            pendFreq_d[i]  = cfg_freq;
            pendLimit_d[i] = cfg_limit;
            pend_d[i]      = 1'b1;
         end else if (chCommit[i]) begin
            pend_d[i] = 1'b0;
         end

         if (chCommit[i]) begin
            actFreq_d[i]  = pendFreq_q[i];
            actLimit_d[i] = pendLimit_q[i];
         end

         if (!ch_enable[i] || ch_restart[i]) begin
            acc_d[i] = '0;
            sub_d[i] = '0;
         end else if (chTick[i]) begin
            acc_d[i]  = acc_q[i] - ACC_W'(actLimit_q[i]);
            ceOs_d[i] = 1'b1;
            if (sub_q[i] == SUB_LAST) begin
               sub_d[i]   = '0;
               ceBit_d[i] = 1'b1;
            end else begin
               sub_d[i] = sub_q[i] + SUB_W'(1);
            end
         end else begin
            acc_d[i] = acc_q[i] + ACC_W'(actFreq_q[i]);
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pendFreq_q  <= '0;
         pendLimit_q <= '0;
         actFreq_q   <= '0;
         actLimit_q  <= '0;
         acc_q       <= '0;
         sub_q       <= '0;
         pend_q      <= '0;
         ceOs_q      <= '0;
         ceBit_q     <= '0;
      end else begin
         pendFreq_q  <= pendFreq_d;
         pendLimit_q <= pendLimit_d;
         actFreq_q   <= actFreq_d;
         actLimit_q  <= actLimit_d;
         acc_q       <= acc_d;
         sub_q       <= sub_d;
         pend_q      <= pend_d;
         ceOs_q      <= ceOs_d;
         ceBit_q     <= ceBit_d;
      end
   end

   assign ce_os       = ceOs_q;
   assign ce_bit      = ceBit_q;
   assign cfg_pending = pend_q;

endmodule

// File: tb/tb_baud_gen_multi.sv
// tb_baud_gen_multi
// Self-checking bench for baud_gen_multi. A cycle model predicts the
// outputs for every edge; predictions are queued as stimulus is applied
// and compared once the DUT has produced that edge's outputs. Directed
// checks on pulse spacing and counts sit on top of the per-cycle compare.
// A second, 3-channel instance checks that out-of-range writes are dropped.
module tb_baud_gen_multi;

   localparam int NUM_CH     = 4;
   localparam int FREQ_W     = 12;
   localparam int LIMIT_W    = 16;
   localparam int OVERSAMPLE = 32;
   localparam int CH_W       = 2;

   logic               clock;
   logic               resetN;
   logic               cfgWe;
   logic [CH_W-1:0]    cfgCh;
   logic [FREQ_W-1:0]  cfgFreq;
   logic [LIMIT_W-1:0] cfgLimit;
   logic [NUM_CH-1:0]  chEnable;
   logic [NUM_CH-1:0]  chRestart;
   logic [NUM_CH-1:0]  ceOs;
   logic [NUM_CH-1:0]  ceBit;
   logic [NUM_CH-1:0]  cfgPending;

   logic               cfgWe3;
   logic [CH_W-1:0]    cfgCh3;
   logic [2:0]         chEnable3;
   logic [2:0]         chRestart3;
   logic [2:0]         ceOs3;
   logic [2:0]         ceBit3;
   logic [2:0]         pend3;

   int total;
   int bad;
   int cyc;

   // Reference model state, one entry per channel.
   int mAcc[NUM_CH], mSub[NUM_CH], mActF[NUM_CH], mActL[NUM_CH];
   int mPendF[NUM_CH], mPendL[NUM_CH];
   bit mPend[NUM_CH], mOs[NUM_CH], mBit[NUM_CH];

   logic [3*NUM_CH-1:0] expQ[$];

   // Pulse-spacing statistics gathered from the DUT outputs.
   int lastOsCyc[NUM_CH], lastGap[NUM_CH], maxGap[NUM_CH], osCnt[NUM_CH];
   int lastBitCyc[NUM_CH], bitGap[NUM_CH], bitCnt[NUM_CH];

   baud_gen_multi #(
      .NUM_CH(NUM_CH), .FREQ_W(FREQ_W), .LIMIT_W(LIMIT_W),
      .OVERSAMPLE(OVERSAMPLE), .CH_W(CH_W)
   ) dut (
      .clock(clock), .reset_n(resetN), .cfg_we(cfgWe), .cfg_ch(cfgCh),
      .cfg_freq(cfgFreq), .cfg_limit(cfgLimit), .ch_enable(chEnable),
      .ch_restart(chRestart), .ce_os(ceOs), .ce_bit(ceBit),
      .cfg_pending(cfgPending)
   );

   baud_gen_multi #(
      .NUM_CH(3), .FREQ_W(FREQ_W), .LIMIT_W(LIMIT_W),
      .OVERSAMPLE(OVERSAMPLE), .CH_W(CH_W)
   ) dut3 (
      .clock(clock), .reset_n(resetN), .cfg_we(cfgWe3), .cfg_ch(cfgCh3),
      .cfg_freq(cfgFreq), .cfg_limit(cfgLimit), .ch_enable(chEnable3),
      .ch_restart(chRestart3), .ce_os(ceOs3), .ce_bit(ceBit3),
      .cfg_pending(pend3)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something stalls despite the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)",
                  tag, observed, expected, cyc);
      end
   endtask

   // Advances the model by one edge using the inputs currently driven and
   // queues the outputs the DUT should show after that edge.
   task automatic modelStep();
      logic [NUM_CH-1:0] eOs, eBit, ePend;
      for (int c = 0; c < NUM_CH; c++) begin
         bit tickNow, wrNow, commitNow;
         if (!resetN) begin
            mAcc[c] = 0; mSub[c] = 0; mActF[c] = 0; mActL[c] = 0;
            mPendF[c] = 0; mPendL[c] = 0; mPend[c] = 0; mOs[c] = 0; mBit[c] = 0;
         end else begin
            tickNow   = (mAcc[c] >= mActL[c]);
            wrNow     = cfgWe && (int'(cfgCh) == c);
            commitNow = !chEnable[c] || chRestart[c] || tickNow;
            if (!chEnable[c] || chRestart[c]) begin
               mAcc[c] = 0; mSub[c] = 0; mOs[c] = 0; mBit[c] = 0;
            end else if (tickNow) begin
               mAcc[c] = mAcc[c] - mActL[c];
               mOs[c]  = 1;
               mBit[c] = (mSub[c] == OVERSAMPLE - 1);
               mSub[c] = (mSub[c] + 1) % OVERSAMPLE;
            end else begin
               mAcc[c] = mAcc[c] + mActF[c];
               mOs[c]  = 0;
               mBit[c] = 0;
            end
            if (commitNow) begin
               mActF[c] = mPendF[c];
               mActL[c] = mPendL[c];
               mPend[c] = 0;
            end
            if (wrNow) begin
               mPendF[c] = int'(cfgFreq);
               mPendL[c] = int'(cfgLimit);
               mPend[c]  = 1;
            end
         end
         eOs[c]   = mOs[c];
         eBit[c]  = mBit[c];
         ePend[c] = mPend[c];
      end
      expQ.push_back({ePend, eBit, eOs});
   endtask

   task automatic clearStats();
      for (int c = 0; c < NUM_CH; c++) begin
         lastOsCyc[c] = cyc; lastGap[c] = 0; maxGap[c] = 0; osCnt[c] = 0;
         lastBitCyc[c] = cyc; bitGap[c] = 0; bitCnt[c] = 0;
      end
   endtask

   // One clock cycle: predict, clock, then compare and update statistics.
   task automatic applyStimulus();
      logic [3*NUM_CH-1:0] expVec;
      modelStep();
      @(posedge clock);
      #1;
      cyc++;
      expVec = expQ.pop_front();
      checkOutput("cycle", 32'({cfgPending, ceBit, ceOs}), 32'(expVec));
      for (int c = 0; c < NUM_CH; c++) begin
         if (ceOs[c]) begin
            lastGap[c] = cyc - lastOsCyc[c];
            if (lastGap[c] > maxGap[c]) maxGap[c] = lastGap[c];
            lastOsCyc[c] = cyc;
            osCnt[c]++;
         end
         if (ceBit[c]) begin
            bitGap[c] = cyc - lastBitCyc[c];
            lastBitCyc[c] = cyc;
            bitCnt[c]++;
         end
      end
   endtask

   task automatic writeCfg(input int ch, input int freq, input int limit);
      cfgWe    = 1'b1;
      cfgCh    = CH_W'(ch);
      cfgFreq  = FREQ_W'(freq);
      cfgLimit = LIMIT_W'(limit);
      applyStimulus();
      cfgWe    = 1'b0;
   endtask

   // Steps at least once, until the selected strobe of a channel is seen.
   task automatic waitFor(input int ch, input bit wantBit, input int maxCyc,
                          input string tag);
      int n;
      bit seen;
      n = 0;
      do begin
         applyStimulus();
         n++;
         seen = wantBit ? ceBit[ch] : ceOs[ch];
      end while (!seen && n < maxCyc);
      checkOutput(tag, 32'(seen), 1);
   endtask

   task automatic waitPendClear(input int ch, input int maxCyc, input string tag);
      int n;
      n = 0;
      do begin
         applyStimulus();
         n++;
      end while (cfgPending[ch] && n < maxCyc);
      checkOutput(tag, 32'(cfgPending[ch]), 0);
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0;
      resetN = 1'b0; cfgWe = 1'b0; cfgCh = '0; cfgFreq = '0; cfgLimit = '0;
      chEnable = '0; chRestart = '0;
      cfgWe3 = 1'b0; cfgCh3 = '0; chEnable3 = '0; chRestart3 = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         mAcc[c] = 0; mSub[c] = 0; mActF[c] = 0; mActL[c] = 0;
         mPendF[c] = 0; mPendL[c] = 0; mPend[c] = 0; mOs[c] = 0; mBit[c] = 0;
      end
      clearStats();

      // Reset state.
      repeat (3) applyStimulus();
      checkOutput("rstOs", 32'(ceOs), 0);
      checkOutput("rstBit", 32'(ceBit), 0);
      checkOutput("rstPend", 32'(cfgPending), 0);
      resetN = 1'b1;

      // Program all four channels while disabled: each commits on the
      // following edge, so only the last write is still pending.
      writeCfg(0, 1, 3);
      writeCfg(1, 3, 5);
      writeCfg(2, 1, 1);
      writeCfg(3, 1, 0);
      checkOutput("pendAfterWr", 32'(cfgPending), 32'h8);

      // ch0 at 1/4 and ch1 at 3/8.
      chEnable = 4'b0011;
      repeat (16) applyStimulus();
      clearStats();
      repeat (800) applyStimulus();
      checkOutput("ch1Count800", osCnt[1], 300);
      checkOutput("ch1MaxGap", maxGap[1], 3);
      checkOutput("ch0Count800", osCnt[0], 200);
      checkOutput("ch0OsGap", lastGap[0], 4);
      checkOutput("ch0BitGap", bitGap[0], 128);

      // Reprogram ch0 to 1/8 while running.
      waitFor(0, 1'b0, 10, "c0SyncOs");
      writeCfg(0, 1, 7);
      checkOutput("c0PendSet", 32'(cfgPending[0]), 1);
      waitPendClear(0, 10, "c0PendClr");
      checkOutput("c0OsAtCommit", 32'(ceOs[0]), 1);
      checkOutput("c0OldGap", lastGap[0], 4);
      waitFor(0, 1'b0, 12, "c0NewOs1");
      checkOutput("c0NewGap1", lastGap[0], 8);
      waitFor(0, 1'b0, 12, "c0NewOs2");
      checkOutput("c0NewGap2", lastGap[0], 8);

      // Restart ch2 mid-bit after 17 oversample strobes.
      chEnable = 4'b0111;
      waitFor(2, 1'b1, 200, "c2FirstBit");
      for (int k = 0; k < 17; k++) waitFor(2, 1'b0, 10, "c2CountOs");
      chRestart = 4'b0100;
      applyStimulus();
      chRestart = '0;
      checkOutput("c2RestartOs", 32'(ceOs[2]), 0);
      checkOutput("c2RestartBit", 32'(ceBit[2]), 0);
      clearStats();
      waitFor(2, 1'b1, 200, "c2BitAfterRestart");
      checkOutput("c2OsToBit", osCnt[2], 32);

      // ch3 with limit 0 strobes every cycle.
      chEnable = 4'b1111;
      repeat (2) applyStimulus();
      clearStats();
      repeat (64) applyStimulus();
      checkOutput("ch3OsCount", osCnt[3], 64);
      checkOutput("ch3BitCount", bitCnt[3], 2);
      checkOutput("ch3BitGap", bitGap[3], 32);

      // One-cycle reset in the middle of the run.
      writeCfg(1, 2, 9);
      checkOutput("prePend1", 32'(cfgPending[1]), 1);
      resetN = 1'b0;
      applyStimulus();
      checkOutput("midRstOs", 32'(ceOs), 0);
      checkOutput("midRstBit", 32'(ceBit), 0);
      checkOutput("midRstPend", 32'(cfgPending), 0);
      resetN = 1'b1;

      // Write coinciding with a commit on ch0.
      chEnable = 4'b0001;
      writeCfg(0, 1, 3);
      repeat (10) applyStimulus();
      waitFor(0, 1'b0, 10, "gSyncOs");
      writeCfg(0, 1, 7);
      repeat (2) applyStimulus();
      writeCfg(0, 1, 1);
      checkOutput("gCoincPend", 32'(cfgPending[0]), 1);
      checkOutput("gCoincOs", 32'(ceOs[0]), 1);
      waitPendClear(0, 20, "gPendClr");
      checkOutput("gFirstValGap", lastGap[0], 8);
      waitFor(0, 1'b0, 10, "gSecondValOs");
      checkOutput("gSecondValGap", lastGap[0], 2);

      // Out-of-range write on the 3-channel build is dropped.
      cfgWe3 = 1'b1;
      cfgCh3 = 2'd3;
      applyStimulus();
      cfgWe3 = 1'b0;
      checkOutput("n3Ignore", 32'(pend3), 0);
      cfgWe3 = 1'b1;
      cfgCh3 = 2'd2;
      applyStimulus();
      cfgWe3 = 1'b0;
      checkOutput("n3Accept", 32'(pend3), 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
